full_adder: RTL and testbench
=============================

# full_adder

Parameterizable binary adder with carry-in and carry-out. It is built as a ripple chain of single-bit full-adder cells. The primary sum/carry outputs are purely combinational and independent of clock and reset. A one-stage registered copy with a valid flag is provided for pipelined datapath use. It sits in arithmetic datapaths as a leaf block; WIDTH=1 is the classic single-bit full adder.

## Interface
Parameters:
- WIDTH, 1, operand width in bits (≥1)
- REG_OUT, 1, 1 = build the registered output stage; 0 = registered outputs tied to 0

Ports:
- clk_i  input  1  clock; rising-edge active; used only by the registered stage
- rst_i  input  1  reset; synchronous, active-high
- a_i  input  WIDTH  operand A
- b_i  input  WIDTH  operand B
- cin_i  input  1  carry into bit 0
- sum_o  output  WIDTH  combinational sum, (a_i + b_i + cin_i) mod 2^WIDTH
- cout_o  output  1  combinational carry out of MSB
- ovf_o  output  1  combinational signed overflow: carry into MSB XOR carry out of MSB
- valid_i  input  1  qualifies a_i/b_i/cin_i for the registered stage
- sum_q_o  output  WIDTH  registered sum_o
- cout_q_o  output  1  registered cout_o
- ovf_q_o  output  1  registered ovf_o
- valid_q_o  output  1  registered valid_i

## Operation
- Per bit k: s[k] = a[k] ^ b[k] ^ c[k]; c[k+1] = (a[k] & b[k]) | (c[k] & (a[k] ^ b[k])); c[0] = cin_i.
- sum_o = s[WIDTH-1:0]; cout_o = c[WIDTH]; ovf_o = c[WIDTH] ^ c[WIDTH-1].
- For WIDTH=1, ovf_o = cout_o ^ cin_i.
- Combinational outputs depend only on a_i, b_i, cin_i.
  - They must be correct with clk_i, rst_i and valid_i unconnected or X.
  - They are unaffected by reset.
- Registered stage, on each rising clk_i:
  - rst_i=1: sum_q_o, cout_q_o, ovf_q_o, valid_q_o ← 0.
  - Else valid_i=1: capture sum_o, cout_o, ovf_o; valid_q_o ← 1.
  - Else valid_i=0: valid_q_o ← 0; data registers hold their previous value.
- Reset takes priority over valid_i in the same cycle.
- REG_OUT=0: registered outputs are constant 0 and no flops are inferred.
- No X-propagation masking: X on a data input may produce X on the outputs.

## Timing
- Combinational path: zero-cycle latency; outputs settle within one propagation delay of any input change. Bench samples 10 time units after a stimulus change.
- Registered path: exactly 1-cycle latency from valid_i high to valid_q_o high with matching data.
- Back-to-back valid_i gives one result per cycle; no backpressure and no stall.
- Reset asserted mid-stream: valid_q_o is 0 on the first edge with rst_i=1. The first post-reset result appears one cycle after valid_i is sampled with rst_i=0.
- Reset values: all registered outputs are 0. Combinational outputs have no reset value.

## Structure
- Sub-module full_adder_cell: 1-bit a, b, cin → sum, cout, using the equations above.
  - Instantiated WIDTH times by a generate loop, with the carry chained.
- No shared package needed.
  - Only constant: the reset value 0 for the registered outputs.
  - If a package exists for the arithmetic library, it carries the WIDTH default only.
- Registered stage is a separate always block guarded by a REG_OUT generate.

## Test plan
- WIDTH=1, exhaustive 8 combinations, i = {cin,b,a} for i=0..7, sampled after 10 units:
  - i=0 → sum=0, cout=0
  - i=3 → sum=0, cout=1
  - i=6 → sum=0, cout=1
  - i=7 → sum=1, cout=1
  - Checker reports total/passed/failed counts; pass requires 8/8.
- WIDTH=1, clk_i/rst_i/valid_i left unconnected: the same 8 vectors must still all pass on sum_o/cout_o.
- WIDTH=8 combinational:
  - 0xFF+0x00+1 → sum=0x00, cout=1, ovf=0
  - 0x7F+0x01+0 → sum=0x80, cout=0, ovf=1
  - 0x80+0x80+0 → sum=0x00, cout=1, ovf=1
- WIDTH=8 registered:
  - valid_i pulses with 0x12+0x34+1, then 0xF0+0x20+0.
  - Expect sum_q_o=0x47 with cout_q_o=0 on the next edge, then sum_q_o=0x10 with cout_q_o=1 on the following edge; valid_q_o high for those two cycles only.
- Reset mid-stream:
  - rst_i=1 together with valid_i=1 → registered outputs all 0 after the edge, while sum_o still shows the live combinational result.
  - Release reset → next valid result appears 1 cycle later.
- valid_i=0 hold: after a captured result, deassert valid_i and change the inputs → sum_q_o unchanged, valid_q_o=0.

Source files
------------

// File: rtl/full_adder_pkg.sv
// Arithmetic library package: shared defaults for the adder family.
// Latency: n/a (constants only).
// Backpressure: n/a.
package full_adder_pkg;

    // Default operand width; WIDTH=1 is the classic single-bit full adder.
    localparam int FA_WIDTH_DEFAULT = 1;

endpackage : full_adder_pkg

// File: rtl/full_adder_cell.sv
// Single-bit full-adder cell: sum and carry-out from a, b and carry-in.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the cell is a pure function of its inputs.
module full_adder_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    // Propagate term, shared by the sum and the carry equations.
    logic prop_w;

    assign prop_w = a_i ^ b_i;
    assign sum_o  = prop_w ^ cin_i;
    // Carry is generated by a&b or propagated from cin through a^b.
    assign cout_o = (a_i & b_i) | (cin_i & prop_w);

endmodule : full_adder_cell

// File: rtl/full_adder.sv
// Ripple-carry adder with carry-in, carry-out, signed overflow and optional output register.
// Latency: sum/cout/ovf combinational (0 cycles); *_q_o outputs one cycle after valid_i.
// Backpressure: none; accepts one operand set per cycle, results are never stalled.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH   = FA_WIDTH_DEFAULT,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o,
    input  logic             valid_i,
    output logic [WIDTH-1:0] sum_q_o,
    output logic             cout_q_o,
    output logic             ovf_q_o,
    output logic             valid_q_o
);

    // carry_w[k] is the carry into bit k; carry_w[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0] carry_w;

    assign carry_w[0] = cin_i;

    // Ripple chain: one cell per bit, each cell's carry-out feeds the next cell.
    for (genvar k = 0; k < WIDTH; k++) begin : g_bit
        full_adder_cell u_cell (
            .a_i    (a_i[k]),
            .b_i    (b_i[k]),
            .cin_i  (carry_w[k]),
            .sum_o  (sum_o[k]),
            .cout_o (carry_w[k+1])
        );
    end

    // Signed overflow: carry into the MSB differs from carry out of it.
    // For WIDTH=1 the carry into the MSB is cin_i itself.
    assign cout_o = carry_w[WIDTH];
    assign ovf_o  = carry_w[WIDTH] ^ carry_w[WIDTH-1];

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] sum_q,   sum_d;
        logic             cout_q,  cout_d;
        logic             ovf_q,   ovf_d;
        logic             valid_q, valid_d;

        // Next state: capture the live result when qualified, otherwise hold the data.
        always_comb begin
            sum_d   = sum_q;
            cout_d  = cout_q;
            ovf_d   = ovf_q;
            valid_d = valid_i;
            if (valid_i) begin
                sum_d  = sum_o;
                cout_d = cout_o;
                ovf_d  = ovf_o;
            end
        end

        // Output register; synchronous reset wins over a same-cycle valid_i.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                sum_q   <= '0;
                cout_q  <= 1'b0;
                ovf_q   <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                sum_q   <= sum_d;
                cout_q  <= cout_d;
                ovf_q   <= ovf_d;
                valid_q <= valid_d;
            end
        end

        assign sum_q_o   = sum_q;
        assign cout_q_o  = cout_q;
        assign ovf_q_o   = ovf_q;
        assign valid_q_o = valid_q;
    end else begin : g_noreg
        // Without the register stage the clock, reset and qualifier have no load.
        logic unused_ok;
        assign unused_ok = ^{clk_i, rst_i, valid_i};

        assign sum_q_o   = '0;
        assign cout_q_o  = 1'b0;
        assign ovf_q_o   = 1'b0;
        assign valid_q_o = 1'b0;
    end

endmodule : full_adder

// File: tb/tb_full_adder.sv
// Bench for full_adder: 1-bit exhaustive (with and without clock/reset/valid driven),
// 8-bit combinational corner cases, 8-bit registered stream, mid-stream reset and hold.
// Expected values are hand-computed constants pushed into scoreboard queues.
module tb_full_adder;

    typedef struct {
        int       which;   // 0: u_w1, 1: u_w1x, 2: u_w8
        logic [7:0] sum;
        logic     cout;
        logic     ovf;
        string    name;
    } comb_exp_t;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        string      name;
    } reg_exp_t;

    int n_cmp  = 0;
    int n_fail = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // 1-bit instances share operands
    logic a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
    logic w1_sum, w1_cout, w1_ovf, w1_sq, w1_cq, w1_oq, w1_vq;
    logic w1x_sum, w1x_cout, w1x_ovf, w1x_sq, w1x_cq, w1x_oq, w1x_vq;
    logic x_clk = 1'bx, x_rst = 1'bx, x_vld = 1'bx;

    // 8-bit instance
    logic [7:0] a8 = 8'h00, b8 = 8'h00;
    logic       cin8 = 1'b0, vld8 = 1'b0;
    logic [7:0] w8_sum, w8_sq;
    logic       w8_cout, w8_ovf, w8_cq, w8_oq, w8_vq;

    full_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
        .clk_i(clk), .rst_i(rst), .a_i(a1), .b_i(b1), .cin_i(cin1),
        .sum_o(w1_sum), .cout_o(w1_cout), .ovf_o(w1_ovf), .valid_i(1'b0),
        .sum_q_o(w1_sq), .cout_q_o(w1_cq), .ovf_q_o(w1_oq), .valid_q_o(w1_vq)
    );

    full_adder #(.WIDTH(1), .REG_OUT(1'b0)) u_w1x (
        .clk_i(x_clk), .rst_i(x_rst), .a_i(a1), .b_i(b1), .cin_i(cin1),
        .sum_o(w1x_sum), .cout_o(w1x_cout), .ovf_o(w1x_ovf), .valid_i(x_vld),
        .sum_q_o(w1x_sq), .cout_q_o(w1x_cq), .ovf_q_o(w1x_oq), .valid_q_o(w1x_vq)
    );

    full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
        .clk_i(clk), .rst_i(rst), .a_i(a8), .b_i(b8), .cin_i(cin8),
        .sum_o(w8_sum), .cout_o(w8_cout), .ovf_o(w8_ovf), .valid_i(vld8),
        .sum_q_o(w8_sq), .cout_q_o(w8_cq), .ovf_q_o(w8_oq), .valid_q_o(w8_vq)
    );

    comb_exp_t comb_q[$];
    reg_exp_t  reg_q[$];
    event      comb_ev;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_comb(input int which, input logic [7:0] s, input logic c,
                             input logic o, input string nm);
        comb_exp_t e;
        e.which = which; e.sum = s; e.cout = c; e.ovf = o; e.name = nm;
        comb_q.push_back(e);
    endtask

    task automatic push_reg(input logic [7:0] s, input logic c, input logic o, input string nm);
        reg_exp_t e;
        e.sum = s; e.cout = c; e.ovf = o; e.name = nm;
        reg_q.push_back(e);
    endtask

    // Combinational monitor: 10 units after each stimulus change, check every pending entry.
    comb_exp_t cm;
    logic [7:0] cm_sum;
    logic       cm_cout, cm_ovf;
    initial begin
        forever begin
            @(comb_ev);
            #10;
            while (comb_q.size() > 0) begin
                cm = comb_q.pop_front();
                case (cm.which)
                    0:       begin cm_sum = {7'b0, w1_sum};  cm_cout = w1_cout;  cm_ovf = w1_ovf;  end
                    1:       begin cm_sum = {7'b0, w1x_sum}; cm_cout = w1x_cout; cm_ovf = w1x_ovf; end
                    default: begin cm_sum = w8_sum;          cm_cout = w8_cout;  cm_ovf = w8_ovf;  end
                endcase
                check({cm.name, ".sum"},  32'(cm_sum),  32'(cm.sum));
                check({cm.name, ".cout"}, 32'(cm_cout), 32'(cm.cout));
                if (cm.which != 1)
                    check({cm.name, ".ovf"}, 32'(cm_ovf), 32'(cm.ovf));
            end
        end
    end

    // Registered monitor: whenever u_w8 presents valid_q_o, pop and compare.
    reg_exp_t rm;
    initial begin
        forever begin
            @(negedge clk);
            if (w8_vq === 1'b1) begin
                if (reg_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL reg_unexpected: valid_q_o=1 with sum_q=0x%0h, expected no result (t=%0t)",
                             w8_sq, $time);
                end else begin
                    rm = reg_q.pop_front();
                    check({rm.name, ".sum_q"},  32'(w8_sq), 32'(rm.sum));
                    check({rm.name, ".cout_q"}, 32'(w8_cq), 32'(rm.cout));
                    check({rm.name, ".ovf_q"},  32'(w8_oq), 32'(rm.ovf));
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    // Hand table for the 1-bit adder, bit i indexed by i = {cin,b,a}.
    logic [7:0] sum1_tbl  = 8'b1001_0110;
    logic [7:0] cout1_tbl = 8'b1110_1000;
    logic [7:0] ovf1_tbl  = 8'b0001_1000;

    initial begin
        // Reset state of the registered outputs
        rst = 1'b1;
        tick();
        tick();
        check("rst.sum_q",   32'(w8_sq), 32'h0);
        check("rst.cout_q",  32'(w8_cq), 32'h0);
        check("rst.ovf_q",   32'(w8_oq), 32'h0);
        check("rst.valid_q", 32'(w8_vq), 32'h0);
        check("rst.w1_valid_q", 32'(w1_vq), 32'h0);
        rst = 1'b0;

        // 1-bit exhaustive, both the wired and the floating-control instance
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            {cin1, b1, a1} = v;
            push_comb(0, {7'b0, sum1_tbl[i]}, cout1_tbl[i], ovf1_tbl[i], $sformatf("w1[%0d]", i));
            push_comb(1, {7'b0, sum1_tbl[i]}, cout1_tbl[i], 1'b0,        $sformatf("w1x[%0d]", i));
            ->comb_ev;
            #12;
        end
        check("w1x.regs_tied", 32'({w1x_sq, w1x_cq, w1x_oq, w1x_vq}), 32'h0);

        // 8-bit combinational corners
        a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1;
        push_comb(2, 8'h00, 1'b1, 1'b0, "w8_ff_00_1");
        ->comb_ev; #12;
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
        push_comb(2, 8'h80, 1'b0, 1'b1, "w8_7f_01_0");
        ->comb_ev; #12;
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
        push_comb(2, 8'h00, 1'b1, 1'b1, "w8_80_80_0");
        ->comb_ev; #12;

        // Registered back-to-back stream
        tick();
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; vld8 = 1'b1;
        push_reg(8'h47, 1'b0, 1'b0, "reg_12_34_1");
        tick();
        check("stream.valid_q_1", 32'(w8_vq), 32'h1);
        a8 = 8'hF0; b8 = 8'h20; cin8 = 1'b0; vld8 = 1'b1;
        push_reg(8'h10, 1'b1, 1'b0, "reg_f0_20_0");
        tick();
        check("stream.valid_q_2", 32'(w8_vq), 32'h1);
        vld8 = 1'b0;
        tick();
        check("stream.valid_q_end", 32'(w8_vq), 32'h0);

        // Hold: inputs change with valid_i low, data registers keep the last result
        a8 = 8'hAA; b8 = 8'h11; cin8 = 1'b1;
        tick();
        tick();
        check("hold.sum_q",   32'(w8_sq), 32'h10);
        check("hold.cout_q",  32'(w8_cq), 32'h1);
        check("hold.valid_q", 32'(w8_vq), 32'h0);

        // Reset mid-stream with valid_i high: reset wins, combinational path stays live
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; vld8 = 1'b1; rst = 1'b1;
        tick();
        check("mrst.sum_q",   32'(w8_sq), 32'h0);
        check("mrst.cout_q",  32'(w8_cq), 32'h0);
        check("mrst.ovf_q",   32'(w8_oq), 32'h0);
        check("mrst.valid_q", 32'(w8_vq), 32'h0);
        check("mrst.sum_live", 32'(w8_sum), 32'h80);
        check("mrst.ovf_live", 32'(w8_ovf), 32'h1);

        // Release reset: first result one cycle after valid_i sampled with rst low
        rst = 1'b0;
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; vld8 = 1'b1;
        push_reg(8'h00, 1'b1, 1'b1, "reg_post_rst");
        tick();
        check("post_rst.valid_q", 32'(w8_vq), 32'h1);
        vld8 = 1'b0;
        tick();
        check("post_rst.valid_q_end", 32'(w8_vq), 32'h0);
        tick();

        check("reg_scoreboard_drained", 32'(reg_q.size()), 32'h0);
        check("comb_scoreboard_drained", 32'(comb_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_full_adder
